mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable run-time checker that sits beside `computer` and snoops its data-memory write port (`memwrite`, `dataadr`, `writedata`) and PC.
- Holds a loadable table of NUM_CHECKS expected (address, data) writes and reports sticky pass/fail with a fail cause.
- Supports ordered or unordered matching and PC-range and cycle-timeout watchdogs.
- Successor to fixed, hard-coded two-write testbench checks; usable in simulation and on FPGA.

Parameters:
- N, 32, data width of writedata and expected data
- A, 32, width of dataadr, expected address and pc
- NUM_CHECKS, 4, number of expected-write table entries (>=1)
- ORDERED, 1, 1 = entries must match in index order; 0 = any order
- STRICT, 0, 1 = a write matching no pending entry is a failure; 0 = ignored
- PC_LIMIT, 100, pc strictly greater than this value in RUN is a failure
- TIMEOUT_CYCLES, 1024, RUN cycles allowed before timeout failure

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin (or restart) a check run
- cfg_we  in  1  write table entry, honoured only in IDLE
- cfg_idx  in  $clog2(NUM_CHECKS)  entry index
- cfg_addr  in  A  expected address
- cfg_data  in  N  expected data
- memwrite  in  1  snooped data-memory write enable
- dataadr  in  A  snooped write address
- writedata  in  N  snooped write data
- pc  in  A  snooped program counter
- done  out  1  state is PASS or FAIL
- pass  out  1  run completed with all valid entries matched
- fail  out  1  run failed
- fail_code  out  3  0 none, 1 data mismatch, 2 unexpected write, 3 pc range, 4 timeout
- fail_addr  out  A  dataadr (or pc for code 3) at failure
- fail_data  out  N  writedata at failure (0 for codes 3/4)
- match_mask  out  NUM_CHECKS  entries matched this run
- cycle_count  out  32  RUN cycles elapsed, saturating

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; every table valid bit cleared.
- FSM states are IDLE, RUN, PASS, FAIL. All outputs are registered.
- IDLE:
  - cfg_we sets entry[cfg_idx] = {valid=1, cfg_addr, cfg_data}.
  - start -> RUN next edge; clears match_mask, cycle_count, fail_* and the ordered pointer.
- cfg_we outside IDLE is ignored.
- start in PASS/FAIL -> RUN with the same clearing; the table is retained.
- start in RUN restarts the run (same clearing).
- RUN, every cycle: cycle_count += 1, saturating at 2^32-1.
- Pending entry = valid and not yet in match_mask.
- ORDERED=1: the candidate is the lowest-index pending entry only.
- ORDERED=0: the candidate is the lowest-index pending entry whose address equals dataadr.
- On memwrite with a candidate address hit:
  - data equal -> set that match_mask bit.
  - data unequal -> FAIL, code 1.
- On memwrite with no candidate hit: STRICT=1 -> FAIL, code 2; STRICT=0 -> ignored.
- Same-cycle priority: code1 > code2 > completion > code3 (pc > PC_LIMIT) > code4 (cycle_count == TIMEOUT_CYCLES-1).
- Completion (match_mask incl. this cycle's update == valid mask) -> PASS next edge. The last matching write is therefore reflected in pass one cycle after it.
- Zero valid entries: PASS on the first RUN cycle.
- FAIL captures fail_code, fail_addr and fail_data on the transition edge.
- PASS/FAIL are sticky: inputs are ignored except start and reset. cycle_count freezes.
- pass = (state == PASS); fail = (state == FAIL); done = pass | fail.
- Reset mid-run returns immediately to the reset condition.

Decomposition:
- Package mwc_pkg holds the state enum (IDLE, RUN, PASS, FAIL), the fail_code enum (FC_NONE..FC_TIMEOUT) and an entry struct {valid, addr, data} parametrised via localparams.
- One sub-module, mwc_expect_table: the register array with the write port and a per-entry address-hit / data-hit vector.
- The top-level module holds the FSM, the candidate priority encoder and the counters.

Test Plan:
- Entry0=(1, 0x0C0C000A), entry1=(63, 0), ORDERED=1; start; writes (1, 0x0C0C000A) then (63, 0) -> match_mask=2'b11, pass=1 one cycle after the second write, fail_code=0.
- Same table, ORDERED=1, STRICT=1; first write (63, 0) -> fail=1, fail_code=2, fail_addr=63. With STRICT=0 the same write is ignored; then (1, 0x0C0C000A), (63, 0) -> pass.
- ORDERED=0; writes (63, 0) then (1, 0x0C0C000A) -> pass. Separately, write (1, 0xDEADBEEF) -> fail_code=1, fail_data=0xDEADBEEF, match_mask unchanged.
- Entries pending; pc=101 -> fail_code=3, fail_addr=101. If a completing write occurs the same cycle with pc=101 -> pass instead.
- TIMEOUT_CYCLES=16, no writes -> fail_code=4 on the edge after cycle_count=15. Then start -> RUN, cycle_count=0, table retained.
- Reset pulsed low mid-RUN with one entry matched -> all outputs 0 immediately, table cleared. start with no cfg -> pass=1 after one RUN cycle.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM states, failure causes and
// the expected-write entry layout.
package mwc_pkg;

  localparam int ENTRY_A = 32;
  localparam int ENTRY_N = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE       = 3'd0,
    FC_DATA       = 3'd1,
    FC_UNEXPECTED = 3'd2,
    FC_PC_RANGE   = 3'd3,
    FC_TIMEOUT    = 3'd4
  } fail_code_t;

  // Reference layout of one expected write at the default widths; the table
  // keeps the same three fields in separate arrays so N and A stay free.
  typedef struct packed {
    logic               valid;
    logic [ENTRY_A-1:0] addr;
    logic [ENTRY_N-1:0] data;
  } entry_t;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mwc_expect_table.sv
// Expected-write table: loadable (address, data) entries with valid bits,
// plus per-entry address and data comparisons against the snooped write.
module mwc_expect_table
  import mwc_pkg::*;
#(
  parameter int N          = 32,
  parameter int A          = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IW         = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IW-1:0]         idx,
  input  logic [A-1:0]          addr,
  input  logic [N-1:0]          data,
  input  logic [A-1:0]          dataadr,
  input  logic [N-1:0]          writedata,
  output logic [NUM_CHECKS-1:0] valid_mask,
  output logic [NUM_CHECKS-1:0] addr_hit,
  output logic [NUM_CHECKS-1:0] data_hit
);

  logic [A-1:0] addr_q [NUM_CHECKS];
  logic [N-1:0] data_q [NUM_CHECKS];

  // Entry storage: reset wipes every entry, a write fills one and marks it valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_mask <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (idx == IW'(i)) begin
          valid_mask[i] <= 1'b1;
          addr_q[i]     <= addr;
          data_q[i]     <= data;
        end
      end
    end
  end

  // Per-entry comparison of the snooped write against each stored entry
  always_comb begin
    addr_hit = '0;
    data_hit = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      addr_hit[i] = (addr_q[i] == dataadr);
      data_hit[i] = (data_q[i] == writedata);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Run-time checker snooping a CPU data-memory write port and PC. Matches
// writes against a table of expected writes and reports sticky pass/fail.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int N              = 32,
  parameter int A              = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int ORDERED        = 1,
  parameter int STRICT         = 0,
  parameter int PC_LIMIT       = 100,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [A-1:0]          cfg_addr,
  input  logic [N-1:0]          cfg_data,
  input  logic                  memwrite,
  input  logic [A-1:0]          dataadr,
  input  logic [N-1:0]          writedata,
  input  logic [A-1:0]          pc,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [2:0]            fail_code,
  output logic [A-1:0]          fail_addr,
  output logic [N-1:0]          fail_data,
  output logic [NUM_CHECKS-1:0] match_mask,
  output logic [31:0]           cycle_count
);

  state_t                  state_q, state_d;
  fail_code_t              fc_q, fc_d;
  logic [NUM_CHECKS-1:0]   valid_mask, addr_hit, data_hit;
  logic [NUM_CHECKS-1:0]   pending, cand_onehot, new_mask;
  logic                    taken, cand_hit, cand_data_ok, cand_fire;
  logic                    table_we;

  assign table_we  = cfg_we && (state_q == S_IDLE);
  assign fail_code = fc_q;

  mwc_expect_table #(
    .N          (N),
    .A          (A),
    .NUM_CHECKS (NUM_CHECKS),
    .IW         (IW)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .we         (table_we),
    .idx        (cfg_idx),
    .addr       (cfg_addr),
    .data       (cfg_data),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .valid_mask (valid_mask),
    .addr_hit   (addr_hit),
    .data_hit   (data_hit)
  );

  assign pending = valid_mask & ~match_mask;

  // Candidate: lowest-index pending entry, additionally address-qualified when unordered
  always_comb begin
    cand_onehot = '0;
    taken       = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (!taken && pending[i] && (ORDERED != 0 || addr_hit[i])) begin
        cand_onehot[i] = 1'b1;
        taken          = 1'b1;
      end
    end
  end

  assign cand_hit     = |(cand_onehot & addr_hit);
  assign cand_data_ok = |(cand_onehot & data_hit);
  assign cand_fire    = memwrite && cand_hit;

  // Next state and failure cause, checked in priority order during a run
  always_comb begin
    state_d  = state_q;
    fc_d     = FC_NONE;
    new_mask = match_mask;
    if (cand_fire && cand_data_ok) begin
      new_mask = match_mask | cand_onehot;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d = S_RUN;
        end else if (cand_fire && !cand_data_ok) begin
          state_d = S_FAIL;
          fc_d    = FC_DATA;
        end else if (STRICT != 0 && memwrite && !cand_hit) begin
          state_d = S_FAIL;
          fc_d    = FC_UNEXPECTED;
        end else if (new_mask == valid_mask) begin
          state_d = S_PASS;
        end else if (pc > A'(PC_LIMIT)) begin
          state_d = S_FAIL;
          fc_d    = FC_PC_RANGE;
        end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAIL;
          fc_d    = FC_TIMEOUT;
        end
      end
      S_PASS, S_FAIL: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered status, match tracking, cycle counter and failure capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass        <= 1'b0;
      fail        <= 1'b0;
      done        <= 1'b0;
      match_mask  <= '0;
      cycle_count <= '0;
      fc_q        <= FC_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      pass <= (state_d == S_PASS);
      fail <= (state_d == S_FAIL);
      done <= (state_d == S_PASS) || (state_d == S_FAIL);
      if (start) begin
        match_mask  <= '0;
        cycle_count <= '0;
        fc_q        <= FC_NONE;
        fail_addr   <= '0;
        fail_data   <= '0;
      end else if (state_q == S_RUN) begin
        match_mask <= new_mask;
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (state_d == S_FAIL) begin
          fc_q      <= fc_d;
          fail_addr <= (fc_d == FC_PC_RANGE) ? pc : dataadr;
          fail_data <= (fc_d == FC_DATA || fc_d == FC_UNEXPECTED) ? writedata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: three instances (ordered+strict,
// ordered+lenient, unordered+lenient) share stimulus; a reference model
// predicts each run's outcome and a monitor compares when done rises.
module tb_mem_write_checker;

  localparam int NC  = 4;
  localparam int TMO = 16;
  localparam int PCL = 100;
  localparam logic [31:0] DA = 32'h0C0C000A;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0, pc = '0;

  logic        done_o [3];
  logic        pass_o [3];
  logic        fail_o [3];
  logic [2:0]  code_o [3];
  logic [31:0] faddr_o [3];
  logic [31:0] fdata_o [3];
  logic [3:0]  mask_o [3];
  logic [31:0] cnt_o [3];

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_CHECKS(NC), .ORDERED(1), .STRICT(1), .PC_LIMIT(PCL), .TIMEOUT_CYCLES(TMO)) u0 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pc(pc), .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]),
    .fail_code(code_o[0]), .fail_addr(faddr_o[0]), .fail_data(fdata_o[0]),
    .match_mask(mask_o[0]), .cycle_count(cnt_o[0]));

  mem_write_checker #(.NUM_CHECKS(NC), .ORDERED(1), .STRICT(0), .PC_LIMIT(PCL), .TIMEOUT_CYCLES(TMO)) u1 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pc(pc), .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]),
    .fail_code(code_o[1]), .fail_addr(faddr_o[1]), .fail_data(fdata_o[1]),
    .match_mask(mask_o[1]), .cycle_count(cnt_o[1]));

  mem_write_checker #(.NUM_CHECKS(NC), .ORDERED(0), .STRICT(0), .PC_LIMIT(PCL), .TIMEOUT_CYCLES(TMO)) u2 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pc(pc), .done(done_o[2]), .pass(pass_o[2]), .fail(fail_o[2]),
    .fail_code(code_o[2]), .fail_addr(faddr_o[2]), .fail_data(fdata_o[2]),
    .match_mask(mask_o[2]), .cycle_count(cnt_o[2]));

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] pc;
  } cyc_t;

  typedef struct {
    int          dut;
    bit          pass;
    logic [2:0]  code;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic [3:0]  mask;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expq[$];
  cyc_t        stim[$];
  bit          tvalid [NC];
  logic [31:0] taddr [NC];
  logic [31:0] tdata [NC];
  bit          in_idle = 1'b1;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: walk one run's write trace against the expected table
  task automatic modelRun(input int k, input bit ordered, input bit strict);
    exp_t e;
    bit   matched [NC];
    int   cand;
    bit   hit, all_done;
    e = '{dut: k, pass: 1'b0, code: 3'd0, faddr: 32'd0, fdata: 32'd0, mask: 4'd0, cnt: 32'd0};
    for (int j = 0; j < NC; j++) matched[j] = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      cand = -1;
      for (int j = 0; j < NC; j++)
        if (cand < 0 && tvalid[j] && !matched[j] && (ordered || taddr[j] == stim[i].adr)) cand = j;
      hit   = (cand >= 0) && (taddr[cand] == stim[i].adr);
      e.cnt = 32'(i + 1);
      if (stim[i].we && hit && tdata[cand] != stim[i].dat) begin
        e.code = 3'd1; e.faddr = stim[i].adr; e.fdata = stim[i].dat;
        expq.push_back(e);
        return;
      end
      if (stim[i].we && !hit && strict) begin
        e.code = 3'd2; e.faddr = stim[i].adr; e.fdata = stim[i].dat;
        expq.push_back(e);
        return;
      end
      if (stim[i].we && hit) begin
        matched[cand] = 1'b1;
        e.mask[cand]  = 1'b1;
      end
      all_done = 1'b1;
      for (int j = 0; j < NC; j++) if (tvalid[j] && !matched[j]) all_done = 1'b0;
      if (all_done) begin
        e.pass = 1'b1;
        expq.push_back(e);
        return;
      end
      if (stim[i].pc > PCL) begin
        e.code = 3'd3; e.faddr = stim[i].pc;
        expq.push_back(e);
        return;
      end
      if (i == TMO - 1) begin
        e.code = 3'd4; e.faddr = stim[i].adr;
        expq.push_back(e);
        return;
      end
    end
  endtask

  task automatic checkReset();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("u%0d reset done", k), 32'(done_o[k]), 32'd0);
      checkOutput($sformatf("u%0d reset pass", k), 32'(pass_o[k]), 32'd0);
      checkOutput($sformatf("u%0d reset fail", k), 32'(fail_o[k]), 32'd0);
      checkOutput($sformatf("u%0d reset code", k), 32'(code_o[k]), 32'd0);
      checkOutput($sformatf("u%0d reset faddr", k), faddr_o[k], 32'd0);
      checkOutput($sformatf("u%0d reset fdata", k), fdata_o[k], 32'd0);
      checkOutput($sformatf("u%0d reset mask", k), 32'(mask_o[k]), 32'd0);
      checkOutput($sformatf("u%0d reset count", k), cnt_o[k], 32'd0);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checkReset();
    for (int j = 0; j < NC; j++) begin
      tvalid[j] = 1'b0; taddr[j] = '0; tdata[j] = '0;
    end
    in_idle = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic cfgWrite(input int idx, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (in_idle) begin
      tvalid[idx] = 1'b1; taddr[idx] = a; tdata[idx] = d;
    end
  endtask

  task automatic startPulse();
    @(posedge clk); #1;
    start = 1'b1; memwrite = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_idle = 1'b0;
  endtask

  function automatic cyc_t wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    cyc_t c;
    c.we = 1'b1; c.adr = a; c.dat = d; c.pc = p;
    return c;
  endfunction

  function automatic cyc_t idle(input logic [31:0] p);
    cyc_t c;
    c.we = 1'b0; c.adr = '0; c.dat = '0; c.pc = p;
    return c;
  endfunction

  // One full run: predict outcomes, pulse start, play the trace, confirm all outcomes arrived
  task automatic applyStimulus();
    while (stim.size() < TMO) stim.push_back(idle(32'd0));
    modelRun(0, 1'b1, 1'b1);
    modelRun(1, 1'b1, 1'b0);
    modelRun(2, 1'b0, 1'b0);
    startPulse();
    for (int i = 0; i < stim.size(); i++) begin
      memwrite = stim[i].we; dataadr = stim[i].adr; writedata = stim[i].dat; pc = stim[i].pc;
      if (i == 0) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("u%0d start count", k), cnt_o[k], 32'd0);
          checkOutput($sformatf("u%0d start done", k), 32'(done_o[k]), 32'd0);
          checkOutput($sformatf("u%0d start mask", k), 32'(mask_o[k]), 32'd0);
        end
      end
      @(posedge clk); #1;
    end
    memwrite = 1'b0; dataadr = '0; writedata = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL done-timeout: got %0d outcomes outstanding, expected 0", expq.size());
      expq.delete();
    end
    stim.delete();
  endtask

  // Monitor: on each rising done, pop that instance's predicted outcome and compare
  initial begin
    bit   prev [3];
    int   idx;
    exp_t e;
    for (int k = 0; k < 3; k++) prev[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_o[k] && !prev[k]) begin
          idx = -1;
          for (int i = 0; i < expq.size(); i++) if (idx < 0 && expq[i].dut == k) idx = i;
          if (idx < 0) begin
            checks++; errors++;
            $display("[TB] FAIL u%0d unexpected done: got done=1, expected no outcome", k);
          end else begin
            e = expq[idx];
            expq.delete(idx);
            checkOutput($sformatf("u%0d pass", k), 32'(pass_o[k]), 32'(e.pass));
            checkOutput($sformatf("u%0d fail", k), 32'(fail_o[k]), 32'(!e.pass));
            checkOutput($sformatf("u%0d fail_code", k), 32'(code_o[k]), 32'(e.code));
            checkOutput($sformatf("u%0d fail_addr", k), faddr_o[k], e.faddr);
            checkOutput($sformatf("u%0d fail_data", k), fdata_o[k], e.fdata);
            checkOutput($sformatf("u%0d match_mask", k), 32'(mask_o[k]), 32'(e.mask));
            checkOutput($sformatf("u%0d cycle_count", k), cnt_o[k], e.cnt);
          end
        end
        prev[k] = done_o[k];
      end
    end
  end

  initial begin
    logic [31:0] pool [4];
    int          ent;
    cyc_t        c;
    pool[0] = 32'd1; pool[1] = 32'd63; pool[2] = 32'd8; pool[3] = 32'd12;

    // Two-write program in order, then out of order, bad data, pc range, timeout
    doReset();
    cfgWrite(0, 32'd1, DA);
    cfgWrite(1, 32'd63, 32'd0);
    stim.push_back(wr(32'd1, DA, 32'd4));
    stim.push_back(wr(32'd63, 32'd0, 32'd8));
    applyStimulus();

    cfgWrite(0, 32'd1, 32'hFFFF_FFFF);
    stim.push_back(wr(32'd63, 32'd0, 32'd4));
    stim.push_back(wr(32'd1, DA, 32'd8));
    stim.push_back(wr(32'd63, 32'd0, 32'd12));
    applyStimulus();

    stim.push_back(wr(32'd1, 32'hDEADBEEF, 32'd4));
    applyStimulus();

    stim.push_back(idle(32'd101));
    applyStimulus();

    stim.push_back(wr(32'd1, DA, 32'd100));
    stim.push_back(wr(32'd63, 32'd0, 32'd101));
    applyStimulus();

    applyStimulus();

    stim.push_back(wr(32'd1, DA, 32'd4));
    stim.push_back(wr(32'd63, 32'd0, 32'd8));
    applyStimulus();

    // Reset in the middle of a run with one entry already matched
    cfgWrite(2, 32'd8, 32'd5);
    startPulse();
    memwrite = 1'b1; dataadr = 32'd1; writedata = DA; pc = 32'd4;
    @(posedge clk); #1;
    memwrite = 1'b0; dataadr = '0; writedata = '0; pc = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("u%0d mid-run mask", k), 32'(mask_o[k]), 32'd1);
    doReset();
    applyStimulus();

    // Randomized runs: fresh tables after reset or retained tables on restart
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        doReset();
        ent = $urandom_range(0, 6);
        for (int n = 0; n < ent; n++)
          cfgWrite($urandom_range(0, NC - 1), pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 2) == 0) begin
        cfgWrite($urandom_range(0, NC - 1), pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
      end
      for (int i = 0; i < $urandom_range(1, 8); i++) begin
        ent   = $urandom_range(0, NC - 1);
        c.we  = ($urandom_range(0, 9) < 7);
        c.adr = ($urandom_range(0, 9) < 7) ? taddr[ent] : pool[$urandom_range(0, 3)];
        c.dat = ($urandom_range(0, 9) < 8) ? tdata[ent] : 32'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) c.pc = 32'(101 + $urandom_range(0, 5));
        else if ($urandom_range(0, 4) == 0) c.pc = 32'd100;
        else c.pc = 32'($urandom_range(0, 99));
        stim.push_back(c);
      end
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
